// File: rtl/fanout_fork_buffer_if.sv
// Handshake bundle between the upstream producer, the fork buffer and its fanout destinations.
// The slave modport is the fork buffer's view; master is the surrounding fabric.
interface fanout_fork_buffer_if #(
  parameter int NUM_DST    = 6,
  parameter int DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_DST-1:0]    out_valid;
  logic [NUM_DST-1:0]    out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fanout_fork_buffer.sv
// Registered eager-fork stage: holds one token and tracks which enabled destinations still owe
// a handshake, releasing upstream as soon as the last live destination has taken it.
module fanout_fork_buffer #(
  parameter int NUM_DST    = 6,
  parameter int DATA_WIDTH = 17,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [NUM_DST-1:0]   dst_en,
  fanout_fork_buffer_if.slave  bus,
  output logic [CNT_WIDTH-1:0] acc_count
);

  logic                  full_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [NUM_DST-1:0]    pend_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic [NUM_DST-1:0]    live_s;
  logic [NUM_DST-1:0]    done_s;
  logic [NUM_DST-1:0]    remain_s;
  logic                  drain_s;
  logic                  in_ready_s;
  logic                  acc_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    logic [CNT_WIDTH-1:0] result;
    if (value == {CNT_WIDTH{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

  // Live obligations: a cleared dst_en bit drops its destination at once.
  always_comb begin
    live_s     = pend_r & dst_en;
    done_s     = live_s & bus.out_ready;
    remain_s   = live_s & ~done_s;
    drain_s    = ~full_r | (remain_s == {NUM_DST{1'b0}});
    in_ready_s = clk_en & drain_s;
    acc_s      = bus.in_valid & in_ready_s;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = {NUM_DST{clk_en & full_r}} & live_s;
  assign bus.out_data  = data_r;
  assign acc_count     = cnt_r;

  // Holding register, pending mask and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      data_r <= {DATA_WIDTH{1'b0}};
      pend_r <= {NUM_DST{1'b0}};
      cnt_r  <= {CNT_WIDTH{1'b0}};
    end else if (clk_en) begin
      if (acc_s && (dst_en == {NUM_DST{1'b0}})) begin
        // Nobody to deliver to: count the token and discard it.
        full_r <= 1'b0;
        pend_r <= {NUM_DST{1'b0}};
        cnt_r  <= sat_inc(cnt_r);
      end else if (acc_s) begin
        data_r <= bus.in_data;
        full_r <= 1'b1;
        pend_r <= dst_en;
        cnt_r  <= sat_inc(cnt_r);
      end else if (full_r && (remain_s == {NUM_DST{1'b0}})) begin
        full_r <= 1'b0;
        pend_r <= {NUM_DST{1'b0}};
      end else if (full_r) begin
        pend_r <= remain_s;
      end else begin
        pend_r <= pend_r;
      end
    end else begin
      full_r <= full_r;
    end
  end

endmodule
